// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the shared memory port.
// The slave modport is the arbiter's view; master is the requesters/memory environment.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;

  logic        m_req_o;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic        m_gnt_i;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
    input  m_gnt_i, m_rvalid_i, m_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
    output m_gnt_i, m_rvalid_i, m_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and data,
// with data priority bounded by a starvation limit and a response timeout in WAIT.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          pick_data;
  logic          gnt;
  logic          rsp;
  logic          rsp_err;
  logic [31:0]   rsp_data;
  logic          in_req;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    wait_d    = wait_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pick_data = 1'b0;
    gnt       = 1'b0;
    rsp       = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    case (state_q)
      IDLE: begin
        if (bus.if_req_i || bus.d_req_i) begin
          // Data has priority unless fetch has been passed over STARVE_LIMIT times.
          pick_data = bus.d_req_i && !(bus.if_req_i && (starve_q == STARVE_MAX));
          owner_d   = pick_data;
          if (pick_data) begin
            we_d    = bus.d_we_i;
            be_d    = bus.d_be_i;
            addr_d  = bus.d_addr_i;
            wdata_d = bus.d_wdata_i;
          end else begin
            we_d    = 1'b0;
            be_d    = 4'hF;
            addr_d  = bus.if_addr_i;
            wdata_d = '0;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.m_gnt_i) begin
          gnt     = 1'b1;
          wait_d  = '0;
          state_d = WAIT;
          if (!owner_q) begin
            starve_d = '0;
          end else if (bus.if_req_i && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        // A real response beats a timeout landing in the same cycle.
        if (bus.m_rvalid_i) begin
          rsp      = 1'b1;
          rsp_data = bus.m_rdata_i;
          state_d  = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          rsp      = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      wait_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Memory side shows only the latched request, and only while in REQ.
  assign in_req        = (state_q == REQ);
  assign bus.m_req_o   = in_req;
  assign bus.m_we_o    = in_req & we_q;
  assign bus.m_be_o    = in_req ? be_q : 4'h0;
  assign bus.m_addr_o  = in_req ? addr_q : 32'h0;
  assign bus.m_wdata_o = in_req ? wdata_q : 32'h0;

  assign bus.if_gnt_o    = gnt & ~owner_q;
  assign bus.if_rvalid_o = rsp & ~owner_q;
  assign bus.if_err_o    = rsp_err & ~owner_q;
  assign bus.if_rdata_o  = (rsp & ~owner_q) ? rsp_data : 32'h0;
  assign bus.d_gnt_o     = gnt & owner_q;
  assign bus.d_rvalid_o  = rsp & owner_q;
  assign bus.d_err_o     = rsp_err & owner_q;
  assign bus.d_rdata_o   = (rsp & owner_q) ? rsp_data : 32'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: a scoreboard of expected responses is filled as
// requests are issued and drained as the arbiter returns them.
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;

  typedef struct packed {
    logic        own;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  rsp_t sb_q[$];
  rsp_t exp_r;

  // Observations from the last mem_serve call.
  int          o_lat;
  int          o_wcyc;
  bit          o_ok;
  bit          o_extra_gnt;
  logic [1:0]  o_gnts;
  logic [1:0]  o_rvs;
  logic [1:0]  o_errs;
  logic [31:0] o_rdata;
  logic [31:0] o_maddr;
  logic        o_mwe;
  logic [3:0]  o_mbe;
  logic [31:0] o_mwdata;

  function automatic rsp_t mk(input logic own, input logic err, input logic [31:0] rdata);
    rsp_t r;
    r.own   = own;
    r.err   = err;
    r.rdata = rdata;
    return r;
  endfunction

  function automatic logic [139:0] all_out();
    return {bus.if_gnt_o, bus.if_rvalid_o, bus.if_rdata_o, bus.if_err_o,
            bus.d_gnt_o, bus.d_rvalid_o, bus.d_rdata_o, bus.d_err_o,
            bus.m_req_o, bus.m_we_o, bus.m_be_o, bus.m_addr_o, bus.m_wdata_o};
  endfunction

  task automatic drive_idle();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.d_req_i    = 1'b0;
    bus.d_we_i     = 1'b0;
    bus.d_be_i     = '0;
    bus.d_addr_i   = '0;
    bus.d_wdata_i  = '0;
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i  = '0;
  endtask

  // Memory model: entered just after a negedge with requests driven; grants in the
  // first REQ cycle, answers in WAIT cycle rsp_delay (or never), returns at a negedge.
  task automatic mem_serve(input int rsp_delay, input bit send_rsp,
                           input logic [31:0] data, input bit drop_req);
    o_ok = 0; o_extra_gnt = 0; o_lat = 0; o_wcyc = 0;
    o_gnts = '0; o_rvs = '0; o_errs = '0; o_rdata = '0;
    o_maddr = '0; o_mwe = 1'b0; o_mbe = '0; o_mwdata = '0;
    #1;
    while (bus.m_req_o !== 1'b1 && o_lat < 8) begin
      @(negedge clk); #1;
      o_lat++;
    end
    if (bus.m_req_o !== 1'b1) return;
    o_maddr  = bus.m_addr_o;
    o_mwe    = bus.m_we_o;
    o_mbe    = bus.m_be_o;
    o_mwdata = bus.m_wdata_o;
    bus.m_gnt_i = 1'b1;
    #1;
    o_gnts = {bus.d_gnt_o, bus.if_gnt_o};
    @(negedge clk);
    bus.m_gnt_i = 1'b0;
    if (drop_req) begin
      bus.if_req_i = 1'b0;
      bus.d_req_i  = 1'b0;
    end
    for (int n = 1; n <= TIMEOUT + 2; n++) begin
      if (send_rsp && n == rsp_delay) begin
        bus.m_rvalid_i = 1'b1;
        bus.m_rdata_i  = data;
      end
      #1;
      if (bus.if_gnt_o || bus.d_gnt_o) o_extra_gnt = 1;
      if (bus.if_rvalid_o || bus.d_rvalid_o) begin
        o_rvs   = {bus.d_rvalid_o, bus.if_rvalid_o};
        o_errs  = {bus.d_err_o, bus.if_err_o};
        o_rdata = bus.if_rdata_o | bus.d_rdata_o;
        o_wcyc  = n;
        o_ok    = 1;
      end
      @(negedge clk);
      bus.m_rvalid_i = 1'b0;
      bus.m_rdata_i  = '0;
      if (o_ok) break;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    bus.if_req_i   = 1'b1;
    bus.m_rvalid_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    n_cmp++;
    if (all_out() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out());
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus.m_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_req: got %b expected 0", bus.m_req_o);
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0100;
    sb_q.push_back(mk(1'b0, 1'b0, 32'h0050_0093));
    mem_serve(2, 1'b1, 32'h0050_0093, 1'b1);
    exp_r = sb_q.pop_front();
    n_cmp++;
    if (!o_ok) begin n_fail++; $display("FAIL fetch_done: got %0d expected 1", o_ok); end
    n_cmp++;
    if (o_lat !== 1) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 1", o_lat); end
    n_cmp++;
    if ({o_maddr, o_mwe, o_mbe, o_mwdata} !== {32'h100, 1'b0, 4'hF, 32'h0}) begin
      n_fail++; $display("FAIL fetch_mem_req: got %h/%b/%h/%h expected 100/0/f/0", o_maddr, o_mwe, o_mbe, o_mwdata);
    end
    n_cmp++;
    if (o_gnts !== 2'b01 || o_extra_gnt) begin
      n_fail++; $display("FAIL fetch_gnt: got %b extra=%0d expected 01 extra=0", o_gnts, o_extra_gnt);
    end
    n_cmp++;
    if ({o_rvs, o_errs, o_rdata} !== {exp_r.own, ~exp_r.own, 1'b0, exp_r.err, exp_r.rdata}) begin
      n_fail++; $display("FAIL fetch_rsp: got rv=%b err=%b data=%h expected rv=01 err=00 data=%h", o_rvs, o_errs, o_rdata, exp_r.rdata);
    end
    n_cmp++;
    if (o_wcyc !== 2) begin n_fail++; $display("FAIL fetch_rsp_cycle: got %0d expected 2", o_wcyc); end
    #1;
    n_cmp++;
    if ({bus.if_rvalid_o, bus.if_rdata_o} !== 33'h0) begin
      n_fail++; $display("FAIL fetch_idle_rdata: got %b/%h expected 0/0", bus.if_rvalid_o, bus.if_rdata_o);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_be_i    = 4'b0011;
    bus.d_addr_i  = 32'h0000_2000;
    bus.d_wdata_i = 32'hDEAD_BEEF;
    sb_q.push_back(mk(1'b1, 1'b0, 32'h0));
    mem_serve(1, 1'b1, 32'h0, 1'b1);
    exp_r = sb_q.pop_front();
    drive_idle();
    n_cmp++;
    if ({o_maddr, o_mwe, o_mbe, o_mwdata} !== {32'h2000, 1'b1, 4'b0011, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL store_mem_req: got %h/%b/%b/%h expected 2000/1/0011/deadbeef", o_maddr, o_mwe, o_mbe, o_mwdata);
    end
    n_cmp++;
    if (o_gnts !== 2'b10) begin n_fail++; $display("FAIL store_gnt: got %b expected 10", o_gnts); end
    n_cmp++;
    if (o_rvs !== {exp_r.own, ~exp_r.own} || o_errs !== {exp_r.err, 1'b0}) begin
      n_fail++; $display("FAIL store_rsp: got rv=%b err=%b expected rv=10 err=00", o_rvs, o_errs);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    bus.d_req_i  = 1'b1;
    bus.d_be_i   = 4'hF;
    bus.d_addr_i = 32'h0000_3000;
    sb_q.push_back(mk(1'b1, 1'b1, 32'h0));
    mem_serve(0, 1'b0, 32'h0, 1'b1);
    exp_r = sb_q.pop_front();
    drive_idle();
    n_cmp++;
    if (o_wcyc !== TIMEOUT) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", o_wcyc, TIMEOUT); end
    n_cmp++;
    if ({o_rvs, o_errs, o_rdata} !== {exp_r.own, 1'b0, exp_r.err, 1'b0, exp_r.rdata}) begin
      n_fail++; $display("FAIL timeout_rsp: got rv=%b err=%b data=%h expected rv=10 err=10 data=0", o_rvs, o_errs, o_rdata);
    end
    bus.m_rvalid_i = 1'b1;
    bus.m_rdata_i  = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL stale_rvalid_idle: got %h expected 0", all_out()); end
    @(negedge clk);
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i  = '0;
    #1;
    n_cmp++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL stale_rvalid_after: got %h expected 0", all_out()); end
  endtask

  task automatic test_rvalid_vs_timeout();
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0500;
    sb_q.push_back(mk(1'b0, 1'b0, 32'h0000_1234));
    mem_serve(TIMEOUT, 1'b1, 32'h0000_1234, 1'b1);
    exp_r = sb_q.pop_front();
    drive_idle();
    n_cmp++;
    if (o_wcyc !== TIMEOUT) begin n_fail++; $display("FAIL race_cycle: got %0d expected %0d", o_wcyc, TIMEOUT); end
    n_cmp++;
    if ({o_rvs, o_errs, o_rdata} !== {1'b0, 1'b1, 2'b00, exp_r.rdata}) begin
      n_fail++; $display("FAIL race_rsp: got rv=%b err=%b data=%h expected rv=01 err=00 data=%h", o_rvs, o_errs, o_rdata, exp_r.rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    bus.d_req_i  = 1'b1;
    bus.d_be_i   = 4'hF;
    bus.d_addr_i = 32'h0000_4000;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.m_req_o !== 1'b1) begin n_fail++; $display("FAIL rstwait_req: got %b expected 1", bus.m_req_o); end
    bus.m_gnt_i = 1'b1;
    @(negedge clk);
    bus.m_gnt_i = 1'b0;
    bus.d_req_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.m_rvalid_i = 1'b1;
    bus.m_rdata_i  = 32'h0000_ABCD;
    #1;
    n_cmp++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL rstwait_stale: got %h expected 0", all_out()); end
    @(negedge clk);
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i  = '0;
    #1;
    n_cmp++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL rstwait_quiet: got %h expected 0", all_out()); end
    @(negedge clk);
    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h0000_4040;
    sb_q.push_back(mk(1'b1, 1'b0, 32'h0000_0077));
    mem_serve(1, 1'b1, 32'h0000_0077, 1'b1);
    exp_r = sb_q.pop_front();
    drive_idle();
    n_cmp++;
    if ({o_maddr, o_gnts, o_rvs, o_errs, o_rdata} !== {32'h4040, 2'b10, 2'b10, 2'b00, exp_r.rdata}) begin
      n_fail++; $display("FAIL rstwait_next: got addr=%h gnt=%b rv=%b err=%b data=%h expected 4040/10/10/00/%h",
                         o_maddr, o_gnts, o_rvs, o_errs, o_rdata, exp_r.rdata);
    end
  endtask

  task automatic test_contention();
    logic own;
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0600;
    bus.d_req_i   = 1'b1;
    bus.d_be_i    = 4'hF;
    bus.d_addr_i  = 32'h0000_0700;
    for (int i = 0; i < 10; i++) begin
      own = !(i == 4 || i == 9);
      sb_q.push_back(mk(own, 1'b0, 32'h1000 + i));
      mem_serve(1, 1'b1, 32'h1000 + i, 1'b0);
      exp_r = sb_q.pop_front();
      n_cmp++;
      if (o_gnts !== {exp_r.own, ~exp_r.own} || o_lat !== 1) begin
        n_fail++; $display("FAIL contention_gnt[%0d]: got gnt=%b lat=%0d expected gnt=%b lat=1",
                           i, o_gnts, o_lat, {exp_r.own, ~exp_r.own});
      end
      n_cmp++;
      if (o_maddr !== (exp_r.own ? 32'h700 : 32'h600) || o_rvs !== {exp_r.own, ~exp_r.own} || o_rdata !== exp_r.rdata) begin
        n_fail++; $display("FAIL contention_rsp[%0d]: got addr=%h rv=%b data=%h expected owner=%b data=%h",
                           i, o_maddr, o_rvs, o_rdata, exp_r.own, exp_r.rdata);
      end
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_timeout();
    test_rvalid_vs_timeout();
    test_reset_in_wait();
    test_contention();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch is pending.
- TIMEOUT, 16, cycles in WAIT before a response is forced.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  reset.
- if_req_i  in  1  fetch request.
- if_addr_i  in  32  fetch address.
- if_gnt_o  out  1  fetch request accepted.
- if_rvalid_o  out  1  fetch response valid.
- if_rdata_o  out  32  fetched instruction.
- if_err_o  out  1  fetch timed out.
- d_req_i  in  1  data request.
- d_we_i  in  1  data write.
- d_be_i  in  4  byte enables.
- d_addr_i  in  32  data address.
- d_wdata_i  in  32  write data.
- d_gnt_o  out  1  data request accepted.
- d_rvalid_o  out  1  data response valid.
- d_rdata_o  out  32  load data.
- d_err_o  out  1  data timed out.
- m_req_o, m_we_o  out  1  memory request and write.
- m_be_o  out  4  memory byte enables.
- m_addr_o, m_wdata_o  out  32  memory address and write data.
- m_gnt_i  in  1  memory accepted request.
- m_rvalid_i  in  1  memory response valid.
- m_rdata_i  in  32  memory read data.
REQ-003 Reset is rst, synchronous, active-high; the clock is clk.

Function
REQ-004 The block SHALL share one memory port between fetch and data with at most one outstanding transaction.
REQ-005 The FSM SHALL have states IDLE, REQ and WAIT, plus a 1-bit owner register (0 = fetch, 1 = data).
REQ-006 IDLE: if any request is present, the block SHALL select the owner, latch that requester's we, be, addr and wdata (fetch: we=0, be=4'hF, wdata=0), and go to REQ.
REQ-007 Arbitration: data SHALL win when both requests are present, unless the starve counter equals STARVE_LIMIT, in which case fetch SHALL win.
REQ-008 The starve counter (3 bits minimum) SHALL increment on each data grant while if_req_i=1, clear on each fetch grant, and saturate at STARVE_LIMIT.
REQ-009 REQ: m_req_o=1 and m_* SHALL be driven from the latched registers only.
REQ-010 REQ: on m_gnt_i=1, the owner's gnt_o SHALL pulse in that same cycle and the FSM SHALL go to WAIT.
REQ-011 Requesters SHALL hold req and payload until gnt; the block SHALL NOT re-sample payload after latching.
REQ-012 WAIT: on m_rvalid_i=1, the owner's rvalid_o SHALL be 1 and rdata_o SHALL equal m_rdata_i in the same cycle (combinational), and the FSM SHALL go to IDLE.
REQ-013 Writes SHALL also complete through rvalid; rdata is don't-care for writes.
REQ-014 The non-owner's gnt_o, rvalid_o and err_o SHALL be 0 at all times.
REQ-015 A WAIT cycle counter SHALL clear on entry to WAIT.
REQ-016 If the WAIT counter reaches TIMEOUT with no m_rvalid_i, the block SHALL pulse the owner's rvalid_o and err_o with rdata_o=0 and go to IDLE.
REQ-017 If m_rvalid_i and the timeout occur in the same cycle, m_rvalid_i SHALL win (normal response, err_o=0).
REQ-018 m_rvalid_i arriving in IDLE or REQ SHALL be ignored.
REQ-019 Latency SHALL be: request at cycle N in IDLE -> m_req_o at N+1.
REQ-020 After a response the FSM SHALL spend at least one cycle in IDLE before the next REQ.
REQ-021 if_rdata_o and d_rdata_o SHALL be 0 whenever the corresponding rvalid_o=0.

Reset
REQ-022 On rst=1 the block SHALL enter IDLE and clear owner, starve counter, WAIT counter and latched registers.
REQ-023 All outputs SHALL be 0 in the cycle following reset.
REQ-024 Reset in REQ or WAIT SHALL abandon the transaction without any gnt, rvalid or err pulse; a later stale m_rvalid_i SHALL be ignored per REQ-018.

Verification
REQ-025 Single fetch: if_addr_i=0x100, m_gnt_i at first REQ cycle, m_rvalid_i 2 cycles later with 0x00500093 -> m_addr_o=0x100, if_gnt_o pulses once, if_rvalid_o with if_rdata_o=0x00500093.
REQ-026 Contention: both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-027 Store: d_we_i=1, d_be_i=4'b0011, addr 0x2000, wdata 0xDEADBEEF -> m_we_o=1, m_be_o=0011, m_wdata_o=0xDEADBEEF, d_rvalid_o on m_rvalid_i, d_err_o=0.
REQ-028 Timeout: m_rvalid_i withheld, TIMEOUT=16 -> 16th WAIT cycle gives d_rvalid_o=1, d_err_o=1, d_rdata_o=0; a later m_rvalid_i in IDLE produces no output.
REQ-029 Reset in WAIT, then m_rvalid_i -> no rvalid_o, all outputs 0, next request proceeds normally.
REQ-030 Simultaneous m_rvalid_i and timeout with 0x1234 -> rvalid_o=1, err_o=0, rdata_o=0x1234.
